// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory read port plus the f_* bundle handed to decode_reg.
// The master side is the fetch stage; the slave side is memory/decode.
interface fetch_stage_if;
    logic [63:0] imem_addr;
    logic [79:0] imem_bytes;
    logic        imem_err;
    logic [2:0]  f_stat;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [63:0] F_predPC;
    logic        f_halted;

    modport master (
        output imem_addr, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, F_predPC, f_halted,
        input  imem_bytes, imem_err
    );

    modport slave (
        input  imem_addr, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, F_predPC, f_halted,
        output imem_bytes, imem_err
    );
endinterface

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, instruction split, valP/predPC, RUN/HALTED issue FSM.
// Optional FETCH_PERF_EN macro adds perf_fetched_o / perf_stalls_o event counters.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned IMEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        F_stall_i,
    input  logic [3:0]  M_icode_i,
    input  logic        M_Cnd_i,
    input  logic [63:0] M_valA_i,
    input  logic [3:0]  W_icode_i,
    input  logic [63:0] W_valM_i,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stalls_o,
`endif
    fetch_stage_if.master fif
);
    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;

    localparam logic [2:0]  STAT_AOK   = 3'd1;
    localparam logic [2:0]  STAT_HLT   = 3'd2;
    localparam logic [2:0]  STAT_ADR   = 3'd3;
    localparam logic [2:0]  STAT_INS   = 3'd4;
    localparam logic [3:0]  REG_NONE   = 4'hF;
    localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_SIZE);

    state_e      state_q, state_d;
    logic [63:0] pred_pc_q, pred_pc_d;

    logic        redirect_m_s, redirect_w_s, redirect_s;
    logic [63:0] f_pc_s;
    logic [3:0]  raw_icode_s, raw_ifun_s;
    logic        need_regids_s, need_valc_s;
    logic [3:0]  len_s;
    logic [64:0] end_addr_s;
    logic [2:0]  stat_s;
    logic [3:0]  icode_s, ra_s, rb_s;
    logic [63:0] valc_s, valp_s, pred_next_s;
    logic        bubble_s;

    // Fetch PC selection: M-stage mispredict outranks W-stage ret.
    always_comb begin
        redirect_m_s = (M_icode_i == 4'h7) && !M_Cnd_i;
        redirect_w_s = (W_icode_i == 4'h9);
        redirect_s   = redirect_m_s || redirect_w_s;
        if (redirect_m_s) begin
            f_pc_s = M_valA_i;
        end else if (redirect_w_s) begin
            f_pc_s = W_valM_i;
        end else begin
            f_pc_s = pred_pc_q;
        end
    end

    // Instruction split, length, status and predicted next PC of the raw fetch.
    always_comb begin
        raw_icode_s = fif.imem_bytes[7:4];
        raw_ifun_s  = fif.imem_bytes[3:0];
        case (raw_icode_s)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids_s = 1'b1;
            default:                                  need_regids_s = 1'b0;
        endcase
        case (raw_icode_s)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc_s = 1'b1;
            default:                      need_valc_s = 1'b0;
        endcase
        len_s      = 4'd1 + {3'd0, need_regids_s} + (need_valc_s ? 4'd8 : 4'd0);
        end_addr_s = {1'b0, f_pc_s} + {61'd0, len_s};

        // Bounds check on the 65-bit sum so a PC near 2^64 cannot wrap past it.
        icode_s = raw_icode_s;
        valp_s  = f_pc_s + {60'd0, len_s};
        if (need_regids_s) begin
            ra_s   = fif.imem_bytes[15:12];
            rb_s   = fif.imem_bytes[11:8];
            valc_s = need_valc_s ? fif.imem_bytes[79:16] : 64'd0;
        end else begin
            ra_s   = REG_NONE;
            rb_s   = REG_NONE;
            valc_s = need_valc_s ? fif.imem_bytes[71:8] : 64'd0;
        end

        if (fif.imem_err || (end_addr_s > IMEM_LIMIT)) begin
            stat_s = STAT_ADR;
        end else if (raw_icode_s > 4'hB) begin
            stat_s = STAT_INS;
            valp_s = f_pc_s + 64'd1;
        end else if (raw_icode_s == 4'h0) begin
            stat_s = STAT_HLT;
        end else begin
            stat_s = STAT_AOK;
        end

        if ((stat_s == STAT_ADR) || (stat_s == STAT_INS)) begin
            icode_s = 4'h1;
            ra_s    = REG_NONE;
            rb_s    = REG_NONE;
            valc_s  = 64'd0;
        end else begin
            icode_s = raw_icode_s;
        end

        if (stat_s != STAT_AOK) begin
            pred_next_s = f_pc_s;
        end else if ((raw_icode_s == 4'h7) || (raw_icode_s == 4'h8)) begin
            pred_next_s = valc_s;
        end else begin
            pred_next_s = valp_s;
        end
    end

    // Output bundle: bubble during reset or while halted with no redirect pending.
    always_comb begin
        bubble_s      = reset || ((state_q == ST_HALTED) && !redirect_s);
        fif.imem_addr = f_pc_s;
        fif.F_predPC  = pred_pc_q;
        fif.f_halted  = (state_q == ST_HALTED);
        if (bubble_s) begin
            fif.f_stat  = STAT_AOK;
            fif.f_icode = 4'h1;
            fif.f_ifun  = 4'h0;
            fif.f_rA    = REG_NONE;
            fif.f_rB    = REG_NONE;
            fif.f_valC  = 64'd0;
            fif.f_valP  = reset ? RESET_PC : pred_pc_q;
        end else begin
            fif.f_stat  = stat_s;
            fif.f_icode = icode_s;
            fif.f_ifun  = raw_ifun_s;
            fif.f_rA    = ra_s;
            fif.f_rB    = rb_s;
            fif.f_valC  = valc_s;
            fif.f_valP  = valp_s;
        end
    end

    // Issue FSM next state and predicted-PC update.
    always_comb begin
        state_d   = state_q;
        pred_pc_d = pred_pc_q;
        if (F_stall_i) begin
            state_d   = state_q;
            pred_pc_d = pred_pc_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    pred_pc_d = pred_next_s;
                    state_d   = (stat_s != STAT_AOK) ? ST_HALTED : ST_RUN;
                end
                ST_HALTED: begin
                    if (redirect_s) begin
                        state_d   = ST_RUN;
                        pred_pc_d = pred_next_s;
                    end else begin
                        state_d   = ST_HALTED;
                        pred_pc_d = pred_pc_q;
                    end
                end
                default: begin
                    state_d   = ST_RUN;
                    pred_pc_d = pred_pc_q;
                end
            endcase
        end
    end

    // F pipeline register and FSM state; reset overrides stall and redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pred_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pred_pc_q <= pred_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stalls_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= 32'd0;
            perf_stalls_q  <= 32'd0;
        end else begin
            if (F_stall_i) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end else if (state_q == ST_RUN) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_stalls_o  = perf_stalls_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed program in a byte-array memory,
// expected f_* bundles queued by the driver and checked by a negedge monitor.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        F_stall = 1'b0;
    logic [3:0]  M_icode = 4'h1;
    logic        M_Cnd = 1'b0;
    logic [63:0] M_valA = 64'd0;
    logic [3:0]  W_icode = 4'h1;
    logic [63:0] W_valM = 64'd0;
    logic        imem_err_r = 1'b0;
    logic [7:0]  mem [0:4095];
    logic [79:0] bytes_s;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        string       name;
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, addr, pred;
        logic        halted;
        logic        chk_perf;
        logic [31:0] perf_stalls;
    } exp_t;

    exp_t sb[$];

    fetch_stage_if fif();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalls;
`endif

    fetch_stage #(.RESET_PC(64'h0), .IMEM_SIZE(4096)) dut (
        .clk       (clk),
        .reset     (reset),
        .F_stall_i (F_stall),
        .M_icode_i (M_icode),
        .M_Cnd_i   (M_Cnd),
        .M_valA_i  (M_valA),
        .W_icode_i (W_icode),
        .W_valM_i  (W_valM),
`ifdef FETCH_PERF_EN
        .perf_fetched_o (perf_fetched),
        .perf_stalls_o  (perf_stalls),
`endif
        .fif       (fif.master)
    );

    always #5 clk = ~clk;

    // Instruction memory model: 10 bytes from imem_addr, zeros past the end.
    always_comb begin
        bytes_s = 80'd0;
        for (int i = 0; i < 10; i++) begin
            logic [63:0] a;
            a = fif.imem_addr + 64'(i);
            bytes_s[i*8 +: 8] = (a < 64'd4096) ? mem[a[11:0]] : 8'h00;
        end
    end
    assign fif.imem_bytes = bytes_s;
    assign fif.imem_err   = imem_err_r;

    task automatic chk(input string tag, input string fld, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got %h, expected %h", tag, fld, act, exp);
    endtask

    // Monitor: compare the presented bundle against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "stat",   64'(fif.f_stat),   64'(e.stat));
            chk(e.name, "icode",  64'(fif.f_icode),  64'(e.icode));
            chk(e.name, "ifun",   64'(fif.f_ifun),   64'(e.ifun));
            chk(e.name, "rA",     64'(fif.f_rA),     64'(e.ra));
            chk(e.name, "rB",     64'(fif.f_rB),     64'(e.rb));
            chk(e.name, "valC",   fif.f_valC,        e.valc);
            chk(e.name, "valP",   fif.f_valP,        e.valp);
            chk(e.name, "addr",   fif.imem_addr,     e.addr);
            chk(e.name, "predPC", fif.F_predPC,      e.pred);
            chk(e.name, "halted", 64'(fif.f_halted), 64'(e.halted));
`ifdef FETCH_PERF_EN
            if (e.chk_perf) chk(e.name, "perf_stalls", 64'(perf_stalls), 64'(e.perf_stalls));
`endif
        end
    end

    function automatic exp_t mk(input string nm, input logic [2:0] st, input logic [3:0] ic,
                                input logic [3:0] ifn, input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] ad,
                                input logic [63:0] pr, input logic h);
        exp_t e;
        e.name = nm; e.stat = st; e.icode = ic; e.ifun = ifn; e.ra = ra; e.rb = rb;
        e.valc = vc; e.valp = vp; e.addr = ad; e.pred = pr; e.halted = h;
        e.chk_perf = 1'b0; e.perf_stalls = 32'd0;
        return e;
    endfunction

    function automatic exp_t bub(input string nm, input logic [63:0] vp, input logic [63:0] ad,
                                 input logic [63:0] pr, input logic h);
        return mk(nm, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, vp, ad, pr, h);
    endfunction

    task automatic step(input logic rst, input logic stall, input logic [3:0] m_ic,
                        input logic [63:0] m_va, input logic [3:0] w_ic, input logic [63:0] w_vm,
                        input logic ierr, input logic push, input exp_t e);
        @(posedge clk);
        #1;
        reset = rst; F_stall = stall; M_icode = m_ic; M_Cnd = 1'b0; M_valA = m_va;
        W_icode = w_ic; W_valM = w_vm; imem_err_r = ierr;
        if (push) sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        // irmovq $10,%rbx @0x00 ; rrmovq %rcx,%rdx @0x0A ; jmp 0x20 @0x0C
        mem[12'h000] = 8'h30; mem[12'h001] = 8'hF3; mem[12'h002] = 8'h0A;
        mem[12'h00A] = 8'h20; mem[12'h00B] = 8'h12;
        mem[12'h00C] = 8'h70; mem[12'h00D] = 8'h20;
        // jne 0x100 @0x20 ; addq @0x29 ; call 0x50 @0x40 ; halt @0x50 ; bad @0x60 ; irmovq @0xFFE
        mem[12'h020] = 8'h74; mem[12'h022] = 8'h01;
        mem[12'h029] = 8'h60; mem[12'h02A] = 8'h01;
        mem[12'h040] = 8'h80; mem[12'h041] = 8'h50;
        mem[12'h050] = 8'h00;
        mem[12'h060] = 8'hC0;
        mem[12'hFFE] = 8'h30; mem[12'hFFF] = 8'hF4;

        step(1'b1, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1, bub("reset", 64'h0, 64'h0, 64'h0, 1'b0));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1,
             mk("irmovq", 3'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'h0A, 64'h00, 64'h00, 1'b0));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1,
             mk("rrmovq", 3'd1, 4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'h0C, 64'h0A, 64'h0A, 1'b0));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1,
             mk("jmp", 3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'h15, 64'h0C, 64'h0C, 1'b0));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1,
             mk("jne", 3'd1, 4'h7, 4'h4, 4'hF, 4'hF, 64'h100, 64'h29, 64'h20, 64'h20, 1'b0));
        step(1'b0, 1'b0, 4'h7, 64'h29, 4'h1, 64'd0, 1'b0, 1'b1,
             mk("mispredict", 3'd1, 4'h6, 4'h0, 4'h0, 4'h1, 64'd0, 64'h2B, 64'h29, 64'h100, 1'b0));
        step(1'b0, 1'b0, 4'h7, 64'h29, 4'h9, 64'h40, 1'b0, 1'b1,
             mk("m_over_w", 3'd1, 4'h6, 4'h0, 4'h0, 4'h1, 64'd0, 64'h2B, 64'h29, 64'h2B, 1'b0));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h9, 64'h40, 1'b0, 1'b1,
             mk("ret_call", 3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h50, 64'h49, 64'h40, 64'h2B, 1'b0));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1,
             mk("halt", 3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h51, 64'h50, 64'h50, 1'b0));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1, bub("halt_bubble", 64'h50, 64'h50, 64'h50, 1'b1));
        step(1'b0, 1'b0, 4'h7, 64'h60, 4'h1, 64'd0, 1'b0, 1'b1,
             mk("wake_ins", 3'd4, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h61, 64'h60, 64'h50, 1'b1));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1,
             mk("ins_run", 3'd4, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h61, 64'h60, 64'h60, 1'b0));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1, bub("ins_bubble", 64'h60, 64'h60, 64'h60, 1'b1));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h9, 64'hFFE, 1'b0, 1'b1,
             mk("wake_adr", 3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h1008, 64'hFFE, 64'h60, 1'b1));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1,
             mk("adr_run", 3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h1008, 64'hFFE, 64'hFFE, 1'b0));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1, bub("adr_frozen", 64'hFFE, 64'hFFE, 64'hFFE, 1'b1));
        step(1'b1, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b0, bub("unused", 64'h0, 64'h0, 64'h0, 1'b0));
        step(1'b1, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1, bub("re_reset", 64'h0, 64'h0, 64'h0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1,
                 mk("stall", 3'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'h0A, 64'h00, 64'h00, 1'b0));
        end
        e = mk("after_stall", 3'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'h0A, 64'h00, 64'h00, 1'b0);
        e.chk_perf = 1'b1; e.perf_stalls = 32'd3;
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1, e);
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b1,
             mk("resume", 3'd1, 4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'h0C, 64'h0A, 64'h0A, 1'b0));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b1, 1'b1,
             mk("imem_err", 3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h15, 64'h0C, 64'h0C, 1'b0));
        step(1'b0, 1'b0, 4'h1, 64'd0, 4'h1, 64'd0, 1'b0, 1'b0, bub("unused", 64'h0, 64'h0, 64'h0, 1'b0));
        repeat (2) @(posedge clk);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
